// File: rtl/seq_norm_ctrl.sv
// Sequential leading-zero normalizer: scans the captured operand one CHUNK-bit
// slice per cycle, MSB first, then applies the final left shift in one extra cycle.
module seq_norm_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [WIDTH-1:0]         Sum,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [WIDTH-1:0]         Norm,
  output logic [$clog2(WIDTH):0]   NormCnt,
  output logic                     Zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NCHUNK - 1);
  localparam logic [CW-1:0] CHUNK_CNT = CW'(CHUNK);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic             fin_q, fin_d;
  logic             zero_pend_q, zero_pend_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic [CW-1:0]    norm_cnt_q, norm_cnt_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] slice;

  // Leading zeros of one slice; only called on nonzero slices, so 0..CHUNK-1.
  function automatic logic [CW-1:0] slice_lzc(input logic [CHUNK-1:0] s);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int b = CHUNK - 1; b >= 0; b--) begin
      if (s[b]) hit = 1'b1;
      else if (!hit) n = n + CW'(1);
    end
    return n;
  endfunction

  always_comb begin
    slice = op_q[(NCHUNK - 1 - int'(idx_q)) * CHUNK +: CHUNK];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    fin_d       = fin_q;
    zero_pend_d = zero_pend_q;
    norm_d      = norm_q;
    norm_cnt_d  = norm_cnt_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (InValid) begin
          op_d        = Sum;
          idx_d       = '0;
          acc_d       = '0;
          fin_d       = 1'b0;
          zero_pend_d = 1'b0;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        if (fin_q) begin
          // Count is settled; the wide barrel shift gets its own cycle.
          norm_d     = zero_pend_q ? '0 : (op_q << acc_q);
          norm_cnt_d = acc_q;
          zero_d     = zero_pend_q;
          fin_d      = 1'b0;
          state_d    = DONE;
        end else if (slice != '0) begin
          acc_d = acc_q + slice_lzc(slice);
          fin_d = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          // Reaches exactly WIDTH, which CW bits hold without wrapping.
          acc_d       = acc_q + CHUNK_CNT;
          zero_pend_d = 1'b1;
          fin_d       = 1'b1;
        end else begin
          acc_d = acc_q + CHUNK_CNT;
          idx_d = idx_q + IW'(1);
        end
      end

      DONE: begin
        if (OutReady) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      fin_q       <= 1'b0;
      zero_pend_q <= 1'b0;
      norm_q      <= '0;
      norm_cnt_q  <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      fin_q       <= fin_d;
      zero_pend_q <= zero_pend_d;
      norm_q      <= norm_d;
      norm_cnt_q  <= norm_cnt_d;
      zero_q      <= zero_d;
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Norm     = norm_q;
  assign NormCnt  = norm_cnt_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_seq_norm_ctrl.sv
// Scoreboard bench for seq_norm_ctrl (WIDTH=32, CHUNK=8): expected results are
// queued at accept time and compared when the result handshake happens.
module tb_seq_norm_ctrl;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic              clk;
  logic              reset;
  logic              InValid;
  logic              InReady;
  logic [WIDTH-1:0]  Sum;
  logic              OutValid;
  logic              OutReady;
  logic [WIDTH-1:0]  Norm;
  logic [5:0]        NormCnt;
  logic              Zero;

  typedef struct {
    logic [31:0] norm;
    logic [5:0]  cnt;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seq_norm_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .Sum      (Sum),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Norm     (Norm),
    .NormCnt  (NormCnt),
    .Zero     (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: leading zeros over the full word, latency from the chunk index.
  function automatic exp_t model(input logic [31:0] s);
    exp_t e;
    int   lz;
    lz = 0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (s[b]) break;
      lz++;
    end
    e.cnt  = 6'(lz);
    e.zero = (s == 32'd0);
    e.norm = e.zero ? 32'd0 : (s << lz);
    e.lat  = (e.zero ? NCH : (lz / CHUNK + 1)) + 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] s);
    int n;
    n = 0;
    while (!InReady && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (InReady !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: InReady=%b required 1", InReady);
    end
    InValid = 1'b1;
    Sum     = s;
    step();
    InValid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (OutValid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    InValid  = 1'b1;
    Sum      = 32'h0000_00FF;
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (InReady !== 1'b1 || OutValid !== 1'b0) begin
        failures++;
        $display("FAIL reset_state: InReady=%b OutValid=%b required 1/0", InReady, OutValid);
      end
    end
    checks++;
    if (Norm !== 32'd0 || NormCnt !== 6'd0 || Zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: Norm=%h NormCnt=%0d Zero=%b required 0/0/0", Norm, NormCnt, Zero);
    end
    InValid = 1'b0;
    reset   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (InReady !== 1'b1 || OutValid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_capture: InReady=%b OutValid=%b required 1/0", InReady, OutValid);
      end
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vec[$];
    exp_t        e;
    int          n;
    vec = '{32'h8000_0000, 32'h00F0_0000, 32'h0000_0001, 32'h0000_0000,
            32'h0001_0000, 32'h0000_8000, 32'h00FF_FFFF};
    for (int i = 0; i < 5; i++) vec.push_back($urandom >> $urandom_range(0, 31));
    foreach (vec[i]) begin
      accept(vec[i]);
      sb.push_back(model(vec[i]));
      wait_valid(n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin
        failures++;
        $display("FAIL latency[%h]: edges=%0d required %0d", vec[i], n, e.lat);
      end
      checks++;
      if (Norm !== e.norm || NormCnt !== e.cnt || Zero !== e.zero) begin
        failures++;
        $display("FAIL result[%h]: Norm=%h NormCnt=%0d Zero=%b required %h/%0d/%b",
                 vec[i], Norm, NormCnt, Zero, e.norm, e.cnt, e.zero);
      end
      OutReady = 1'b1;
      step();
      OutReady = 1'b0;
      checks++;
      if (InReady !== 1'b1 || OutValid !== 1'b0) begin
        failures++;
        $display("FAIL release[%h]: InReady=%b OutValid=%b required 1/0", vec[i], InReady, OutValid);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    accept(32'h00F0_0000);
    sb.push_back(model(32'h00F0_0000));
    wait_valid(n);
    e = sb.pop_front();
    InValid = 1'b1;
    Sum     = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || Norm !== e.norm ||
          NormCnt !== e.cnt || Zero !== e.zero) begin
        failures++;
        $display("FAIL bp_hold[%0d]: OutValid=%b InReady=%b Norm=%h NormCnt=%0d Zero=%b required 1/0/%h/%0d/%b",
                 i, OutValid, InReady, Norm, NormCnt, Zero, e.norm, e.cnt, e.zero);
      end
    end
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle: InReady=%b OutValid=%b required 1/0", InReady, OutValid);
    end
    sb.push_back(model(32'h0000_0001));
    step();
    InValid = 1'b0;
    checks++;
    if (InReady !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept: InReady=%b required 0", InReady);
    end
    wait_valid(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat || Norm !== e.norm || NormCnt !== e.cnt || Zero !== e.zero) begin
      failures++;
      $display("FAIL bp_next: edges=%0d Norm=%h NormCnt=%0d Zero=%b required %0d/%h/%0d/%b",
               n, Norm, NormCnt, Zero, e.lat, e.norm, e.cnt, e.zero);
    end
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    accept(32'h0000_0001);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0 || NormCnt !== 6'd0 || Norm !== 32'd0) begin
      failures++;
      $display("FAIL mid_scan_reset: InReady=%b OutValid=%b NormCnt=%0d Norm=%h required 1/0/0/0",
               InReady, OutValid, NormCnt, Norm);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (OutValid !== 1'b0) begin
        failures++;
        $display("FAIL mid_scan_discard[%0d]: OutValid=%b required 0", i, OutValid);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_norm_ctrl.md
SEQ_NORM_CTRL -- requirements
Module: seq_norm_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width in bits; it must be an integer multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 8, meaning the chunk width scanned per cycle; it must be a power of 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port InValid, input, 1 bit: an operand is offered on Sum.
REQ-006 SHALL have port InReady, output, 1 bit: the block accepts an operand this cycle.
REQ-007 SHALL have port Sum, input, WIDTH bits: the unnormalized operand.
REQ-008 SHALL have port OutValid, output, 1 bit: the result outputs are valid.
REQ-009 SHALL have port OutReady, input, 1 bit: the consumer takes the result this cycle.
REQ-010 SHALL have port Norm, output, WIDTH bits: Sum shifted left by NormCnt, zero-filled.
REQ-011 SHALL have port NormCnt, output, $clog2(WIDTH)+1 bits: leading-zero count, range 0..WIDTH.
REQ-012 SHALL have port Zero, output, 1 bit: the captured operand was all zeros.

Function
REQ-013 SHALL implement an FSM with states IDLE, SCAN and DONE.
REQ-014 In IDLE: InReady=1, OutValid=0; when InValid=1, capture Sum into an operand register, clear the chunk index and count accumulator, and go to SCAN.
REQ-015 In SCAN: InReady=0 and OutValid=0.
REQ-016 In SCAN, each cycle examines exactly one CHUNK-bit slice, MSB-first; index i selects bits [WIDTH-1-i*CHUNK] down to [WIDTH-(i+1)*CHUNK].
REQ-017 If the slice is nonzero: accumulator += leading-zero count of the slice (0..CHUNK-1); register Norm = operand << final count, NormCnt = final count, Zero=0; go to DONE.
REQ-018 If the slice is zero and is not the last slice: accumulator += CHUNK; index += 1; stay in SCAN.
REQ-019 If the slice is zero and is the last slice: register NormCnt=WIDTH, Norm=0, Zero=1; go to DONE.
REQ-020 In DONE: OutValid=1, InReady=0; Norm, NormCnt and Zero hold stable until OutValid && OutReady, then go to IDLE.
REQ-021 SHALL have latency, from the accept edge to the first cycle with OutValid=1, of k+1 clock edges, where k = 1 + index of the first nonzero slice (k = WIDTH/CHUNK for a zero operand).
REQ-022 SHALL ignore InValid outside IDLE; Sum is not sampled outside IDLE.
REQ-023 SHALL give one IDLE cycle between the output handshake and the next accept; no bypass path is required.
REQ-024 SHALL prevent the NormCnt accumulator from overflowing: width $clog2(WIDTH)+1 is sufficient, with no wrap.
REQ-025 SHALL ignore OutReady outside DONE.
REQ-026 SHALL drive all outputs from registers or decoded directly from the state register, with no combinational path from inputs to outputs.

Reset
REQ-027 On reset=1 at a clock edge, regardless of state, the next state SHALL be IDLE, including mid-SCAN or mid-DONE; any in-flight operand is discarded.
REQ-028 Reset values SHALL be: OutValid=0, InReady=1 (IDLE), Norm=0, NormCnt=0, Zero=0, chunk index 0, accumulator 0.
REQ-029 While reset=1 with InValid=1, the block SHALL capture no operand.

Verification (WIDTH=32, CHUNK=8)
REQ-030 Sum=0x80000000 accepted at edge E0 -> OutValid=1 after E2; NormCnt=0, Norm=0x80000000, Zero=0.
REQ-031 Sum=0x00F00000 -> 2 SCAN cycles; NormCnt=8, Norm=0xF0000000, Zero=0.
REQ-032 Sum=0x00000001 -> 4 SCAN cycles, OutValid after E5; NormCnt=31, Norm=0x80000000.
REQ-033 Sum=0x00000000 -> 4 SCAN cycles; NormCnt=32, Norm=0, Zero=1.
REQ-034 Backpressure: result 0x00F00000 with OutReady=0 for 5 cycles and InValid=1 with Sum=0x1 throughout -> outputs hold constant and InReady=0; OutReady=1 -> IDLE next cycle, then 0x1 is accepted.
REQ-035 Reset asserted in the 2nd SCAN cycle of Sum=0x00000001 -> after the edge: IDLE, OutValid=0, InReady=1, NormCnt=0; the operand never appears at the output.
